// File: rtl/usb_tx_bit_stuff_encoder_if.sv
// Handshake and line bundle between the TX byte shifter and the encoder.
// master: upstream shifter side; slave: the bit-stuff/NRZI encoder.
interface usb_tx_bit_stuff_encoder_if;
    logic tx_start;
    logic bit_in;
    logic last_bit;
    logic shift_enable;
    logic d_plus;
    logic d_minus;
    logic busy;
    logic eop_done;

    modport master (
        output tx_start,
        output bit_in,
        output last_bit,
        input  shift_enable,
        input  d_plus,
        input  d_minus,
        input  busy,
        input  eop_done
    );

    modport slave (
        input  tx_start,
        input  bit_in,
        input  last_bit,
        output shift_enable,
        output d_plus,
        output d_minus,
        output busy,
        output eop_done
    );
endinterface

// File: rtl/usb_tx_bit_stuff_encoder.sv
// USB full-speed transmit line encoder: pulls serial data LSB first, inserts
// a stuffed 0 after six consecutive 1s, NRZI-encodes onto D+/D- and appends
// the end-of-packet sequence (SE0, SE0, J).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | line parked at J, waiting for tx_start
// SEND     | one decision per bit period: stuff, start EOP, or shift
// EOP_SE0A | first SE0 bit period
// EOP_SE0B | second SE0 bit period
// EOP_J    | final J bit period; leaving it pulses eop_done
module usb_tx_bit_stuff_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic                        clk,
    input  logic                        n_rst,
    usb_tx_bit_stuff_encoder_if.slave   tx
);

    localparam int TMR_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(CLKS_PER_BIT - 1);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_param
            $error("CLKS_PER_BIT must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEND     = 3'd1,
        EOP_SE0A = 3'd2,
        EOP_SE0B = 3'd3,
        EOP_J    = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Bit timer runs as a down-counter; a bit-period decision happens at
    // terminal count (zero), which is also the value loaded on packet start.
    logic [TMR_W-1:0]  bit_tmr;
    logic [TMR_W-1:0]  bit_tmr_nxt;
    logic              bit_tick;

    logic [2:0]        ones_cnt;
    logic [2:0]        ones_cnt_nxt;
    logic              stuff_due;
    logic              last_seen;
    logic              last_seen_nxt;

    logic              dp_q;
    logic              dm_q;
    logic              dp_nxt;
    logic              dm_nxt;
    logic              eop_q;
    logic              eop_nxt;
    logic              shift_en;

    assign bit_tick  = (bit_tmr == '0);
    assign stuff_due = (ones_cnt == 3'd6);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; every non-IDLE transition waits for a bit tick.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (tx.tx_start) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                // A pending stuff bit outranks the end of packet.
                if (bit_tick && !stuff_due && last_seen) begin
                    state_nxt = EOP_SE0A;
                end
            end
            EOP_SE0A: begin
                if (bit_tick) begin
                    state_nxt = EOP_SE0B;
                end
            end
            EOP_SE0B: begin
                if (bit_tick) begin
                    state_nxt = EOP_J;
                end
            end
            EOP_J: begin
                if (bit_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Per-state outputs and next values of the line, stuff counter and timer.
    always_comb begin
        shift_en      = 1'b0;
        dp_nxt        = dp_q;
        dm_nxt        = dm_q;
        ones_cnt_nxt  = ones_cnt;
        last_seen_nxt = last_seen;
        eop_nxt       = 1'b0;

        // Timer parks at zero in IDLE so the first SEND cycle is a decision.
        if (state == IDLE || state_nxt == IDLE) begin
            bit_tmr_nxt = '0;
        end else if (bit_tick) begin
            bit_tmr_nxt = TMR_RELOAD;
        end else begin
            bit_tmr_nxt = bit_tmr - TMR_W'(1);
        end

        case (state)
            IDLE: begin
                dp_nxt = 1'b1;
                dm_nxt = 1'b0;
                if (tx.tx_start) begin
                    ones_cnt_nxt  = 3'd0;
                    last_seen_nxt = 1'b0;
                end
            end
            SEND: begin
                if (bit_tick) begin
                    if (stuff_due) begin
                        // Stuffed 0: toggle J<->K without consuming data.
                        dp_nxt       = ~dp_q;
                        dm_nxt       = dp_q;
                        ones_cnt_nxt = 3'd0;
                    end else if (last_seen) begin
                        dp_nxt = 1'b0;
                        dm_nxt = 1'b0;
                    end else begin
                        shift_en = 1'b1;
                        if (!tx.bit_in) begin
                            dp_nxt = ~dp_q;
                            dm_nxt = dp_q;
                        end
                        ones_cnt_nxt  = tx.bit_in ? (ones_cnt + 3'd1) : 3'd0;
                        last_seen_nxt = tx.last_bit;
                    end
                end
            end
            EOP_SE0A: begin
                dp_nxt = 1'b0;
                dm_nxt = 1'b0;
            end
            EOP_SE0B: begin
                if (bit_tick) begin
                    dp_nxt = 1'b1;
                    dm_nxt = 1'b0;
                end
            end
            EOP_J: begin
                if (bit_tick) begin
                    eop_nxt = 1'b1;
                end
            end
            default: begin
                dp_nxt = 1'b1;
                dm_nxt = 1'b0;
            end
        endcase
    end

    // Registered line levels, stuff bookkeeping, bit timer and end pulse.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            ones_cnt  <= 3'd0;
            last_seen <= 1'b0;
            bit_tmr   <= '0;
            eop_q     <= 1'b0;
        end else begin
            dp_q      <= dp_nxt;
            dm_q      <= dm_nxt;
            ones_cnt  <= ones_cnt_nxt;
            last_seen <= last_seen_nxt;
            bit_tmr   <= bit_tmr_nxt;
            eop_q     <= eop_nxt;
        end
    end

    assign tx.shift_enable = shift_en;
    assign tx.d_plus       = dp_q;
    assign tx.d_minus      = dm_q;
    assign tx.busy         = (state != IDLE);
    assign tx.eop_done     = eop_q;

    // Structural invariants: run length never passes six, data is only
    // pulled while sending, and the line is differential during SEND.
    a_ones_bounded: assert property (@(posedge clk) disable iff (!n_rst)
        ones_cnt <= 3'd6);
    a_shift_in_send: assert property (@(posedge clk) disable iff (!n_rst)
        shift_en |-> (state == SEND));
    a_send_differential: assert property (@(posedge clk) disable iff (!n_rst)
        (state == SEND) |-> (dp_q != dm_q));

endmodule

// File: doc/usb_tx_bit_stuff_encoder.md
# usb_tx_bit_stuff_encoder

Transmit-side line encoder for the USB full-speed TX path. It pulls serial data bits, LSB first, from the TX shift register. It inserts a stuffed 0 after every six consecutive 1s, NRZI-encodes the result onto d_plus/d_minus, and appends the EOP (SE0, SE0, J). It sits between the TX byte shifter and the bus pads, and mirrors the RX NRZI decoder and bit-stuff detector.

## Interface
- CLKS_PER_BIT, 8: clk cycles per USB bit period (must be ≥ 2).
- clk  in  1  system clock.
- n_rst  in  1  reset, asynchronous, active-low.
- tx_start  in  1  one-cycle pulse that begins a packet; ignored while busy=1.
- bit_in  in  1  next data bit; must be valid whenever shift_enable=1.
- last_bit  in  1  marks bit_in as the final data bit of the packet; qualified by shift_enable.
- shift_enable  out  1  combinational one-cycle strobe: block consumes bit_in/last_bit this cycle, and upstream advances.
- d_plus  out  1  registered D+ line level.
- d_minus  out  1  registered D− line level.
- busy  out  1  high from the cycle after tx_start is accepted until the EOP J bit completes.
- eop_done  out  1  registered one-cycle pulse at packet end.

## Operation
- Line states: J = (d_plus=1, d_minus=0); K = (0,1); SE0 = (0,0). The idle line is J.
- NRZI encoding: a data or stuff bit 0 toggles J↔K; a 1 holds the current level.
- FSM states: IDLE, SEND, EOP_SE0A, EOP_SE0B, EOP_J.
- IDLE:
  - tx_start=1 → SEND.
  - On entry to SEND: timer=0, ones_cnt=0, last_seen=0.
- Bit timer:
  - Counts 0..CLKS_PER_BIT−1 and wraps in every non-IDLE state.
  - A bit-period decision is made only in cycles where timer==0.
- SEND decision at timer==0, in priority order:
  1. ones_cnt==6 → stuff cycle: toggle the line, set ones_cnt=0, shift_enable=0.
  2. last_seen=1 → drive SE0 and go to EOP_SE0A, shift_enable=0.
  3. Otherwise, shift cycle: shift_enable=1, sample bit_in and apply NRZI. ones_cnt becomes ones_cnt+1 if bit_in=1, else 0. last_seen is set to last_bit.
- A stuff bit is inserted even when the sixth 1 was the last data bit; SE0 follows the stuff bit.
- ones_cnt is 3 bits and saturates by construction: it never exceeds 6.
- EOP sequence:
  - EOP_SE0A, at timer==0 → EOP_SE0B, line stays SE0.
  - EOP_SE0B, at timer==0 → EOP_J, drive J.
  - EOP_J, at timer==0 → IDLE, eop_done=1 for one cycle, busy falls.
- tx_start asserted in any non-IDLE state has no effect.
- shift_enable is 0 in every state other than SEND.

## Timing
- Reset values (asynchronous): state=IDLE, d_plus=1, d_minus=0, busy=0, eop_done=0, ones_cnt=0, timer=0, last_seen=0. shift_enable=0 follows combinationally.
- Reset mid-packet returns the line to J immediately. The packet is abandoned and eop_done is not pulsed.
- Start-up sequence:
  - tx_start is sampled at edge E0; state=SEND and busy=1 after E0.
  - shift_enable=1 in the cycle between E0 and E1.
  - The first line level is visible after E1.
- Each line level, including stuff bits and each SE0 bit, is held for exactly CLKS_PER_BIT clocks.
- Periods between consecutive shift_enable pulses:
  - CLKS_PER_BIT clocks normally.
  - 2×CLKS_PER_BIT clocks across a stuff bit.
- After the shift that sampled last_bit=1, with no stuff pending:
  - SE0 begins CLKS_PER_BIT clocks later.
  - eop_done pulses 3×CLKS_PER_BIT clocks after SE0 begins, together with the cycle busy falls.
- Earliest accepted tx_start: the cycle after eop_done.

## Test plan
- Reset and idle: assert n_rst low mid-cycle → d_plus=1, d_minus=0, busy=0, shift_enable=0 immediately. Hold tx_start=0 for 50 cycles → line stays J.
- Sync byte: send 0x80 LSB first (0,0,0,0,0,0,0,1), with last_bit on bit 7 → line sequence K,J,K,J,K,J,K,K, each 8 clocks. Then SE0, SE0, J, then eop_done for one cycle.
- Stuffing: send data bits 0,1,1,1,1,1,1,1,0 → a toggle is inserted after the sixth 1. There are exactly 9 shift_enable pulses over 10 bit periods, and a 16-clock gap appears at the stuff. The line holds for 7 periods after the first toggle except at the stuff toggle.
- Stuff at end: the last six data bits are all 1 with last_bit on the final one → stuff toggle period, then SE0. No shift_enable occurs after last_bit.
- Busy-ignore: pulse tx_start again during SEND and during EOP_SE0B → no restart, and the bit count and eop_done timing are unchanged.
- Reset mid-packet: drop n_rst during the third data bit → line returns to J asynchronously. Check that a new tx_start after release produces a clean sync byte with ones_cnt starting from 0.
